csr_file_m: RTL and testbench

//  Machine-mode CSR file for the NPC core; successor of the fixed 4-register CSR block.
//  - Parametrised register width.
//  - Full CSRRW/CSRRS/CSRRC semantics.
//  - Masked mstatus; trap entry and mret exit.
//  - Illegal-access flag; optional 64-bit cycle/instret counters.

---
 rtl/csr_file_if.sv | 31 +++
 rtl/csr_file_m.sv | 156 +++++++++++++++
 tb/tb_csr_file_m.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// CSR file bus: decode-side CSR access plus exception/commit controls and the
// trap/return targets fed back to the fetch unit.
interface csr_file_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic            mret;
  logic            instr_retire;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] mepc_out;
  logic            mie_out;

  modport master (
    output csr_addr, csr_op, csr_wdata, trap_valid, trap_cause, trap_epc,
           mret, instr_retire,
    input  csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, trap_valid, trap_cause, trap_epc,
           mret, instr_retire,
    output csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: mstatus/misa/mtvec/mscratch/mepc/mcause/mhartid with trap entry
// and mret. Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_file_m #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h80000000,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MISA_VAL  = 'h40001100
) (
  input logic      clk,
  input logic      rst,
  csr_file_if.slave bus
);
  localparam logic [1:0]      OP_NONE = 2'b00;
  localparam logic [1:0]      OP_RW   = 2'b01;
  localparam logic [1:0]      OP_RS   = 2'b10;
  localparam logic [1:0]      OP_RC   = 2'b11;
  localparam logic [XLEN-1:0] ALIGN   = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mstatus_rd, old_val, new_val;
  logic            impl, ro, eff_write, illegal, wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic unused_retire;
  assign unused_retire = bus.instr_retire;
`endif

  // MPP is hardwired to machine mode; only MIE and MPIE have storage.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  always_comb begin
    impl    = 1'b1;
    ro      = 1'b0;
    old_val = '0;
    case (bus.csr_addr)
      12'h300: old_val = mstatus_rd;
      12'h301: begin old_val = MISA_VAL; ro = 1'b1; end
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'hF14: begin old_val = HART_ID; ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      12'hB00: old_val = XLEN'(mcycle_q);
      12'hB02: old_val = XLEN'(minstret_q);
      12'hB80: if (XLEN == 32) old_val = XLEN'(mcycle_q >> 32); else impl = 1'b0;
      12'hB82: if (XLEN == 32) old_val = XLEN'(minstret_q >> 32); else impl = 1'b0;
`endif
      default: impl = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and never counts as a write.
  assign eff_write = (bus.csr_op == OP_RW) ||
                     ((bus.csr_op != OP_NONE) && (bus.csr_wdata != '0));
  assign illegal   = (bus.csr_op != OP_NONE) && (!impl || (ro && eff_write));
  assign wr_en     = eff_write && !illegal && !bus.trap_valid && !bus.mret;

  always_comb begin
    case (bus.csr_op)
      OP_RW:   new_val = bus.csr_wdata;
      OP_RS:   new_val = old_val | bus.csr_wdata;
      OP_RC:   new_val = old_val & ~bus.csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (bus.trap_valid) begin
      mepc_d   = bus.trap_epc & ALIGN;
      mcause_d = bus.trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (bus.mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (bus.csr_addr)
        12'h300: begin mie_d = new_val[3]; mpie_d = new_val[7]; end
        12'h305: mtvec_d    = new_val & ALIGN;
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d     = new_val & ALIGN;
        12'h342: mcause_d   = new_val;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to one half replaces it and suppresses that counter's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, bus.instr_retire};
    if (wr_en) begin
      case (bus.csr_addr)
        12'hB00: mcycle_d = (XLEN == 64) ? 64'(new_val)
                                         : {mcycle_q[63:32], new_val[31:0]};
        12'hB02: minstret_d = (XLEN == 64) ? 64'(new_val)
                                           : {minstret_q[63:32], new_val[31:0]};
        12'hB80: mcycle_d   = {new_val[31:0], mcycle_q[31:0]};
        12'hB82: minstret_d = {new_val[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign bus.csr_rdata   = old_val;
  assign bus.csr_illegal = illegal;
  assign bus.trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
  assign bus.mepc_out    = mepc_q;
  assign bus.mie_out     = mie_q;
endmodule

// File: tb/tb_csr_file_m.sv
// Randomized bench for csr_file_m (XLEN=32) against an architectural model of the CSRs;
// counter checks follow CSR_COUNTERS_EN.
module tb_csr_file_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_file_if #(.XLEN(32)) bus();
  csr_file_m #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 32'h80000000; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] v,
                                     output bit impl, output bit ro);
    impl = 1; ro = 0; v = 0;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: begin v = 32'h40001100; ro = 1; end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hF14: begin v = 32'h0; ro = 1; end
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
`endif
      default: impl = 0;
    endcase
  endfunction

  task automatic cyc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w,
                     input logic tv, input logic [31:0] tc, input logic [31:0] te,
                     input logic mr, input logic ir,
                     output logic [31:0] rd, output logic ill);
    logic [31:0] o, nv;
    bit impl, ro, eff, exp_ill, cyc_wr, ins_wr;
    @(negedge clk);
    bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = w;
    bus.trap_valid = tv; bus.trap_cause = tc; bus.trap_epc = te;
    bus.mret = mr; bus.instr_retire = ir;
    #1;
    model_read(a, o, impl, ro);
    eff     = (op == 2'b01) || (op != 2'b00 && w != 0);
    exp_ill = (op != 2'b00) && (!impl || (ro && eff));
    rd  = bus.csr_rdata;
    ill = bus.csr_illegal;
    check("rdata", rd, o);
    check("illegal", ill, exp_ill);
    $display("txn addr=%h op=%0d w=%h trap=%0b mret=%0b ret=%0b rd=%h ill=%0b",
             a, op, w, tv, mr, ir, rd, ill);
    nv = (op == 2'b01) ? w : (op == 2'b10) ? (o | w) : (o & ~w);
    cyc_wr = 0; ins_wr = 0;
    @(posedge clk);
    if (tv) begin
      m_mepc = te & 32'hFFFF_FFFC; m_mcause = tc; m_mpie = m_mie; m_mie = 0;
    end else if (mr) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (eff && !exp_ill) begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause   = nv;
        12'hB00: begin m_cycle[31:0]    = nv; cyc_wr = 1; end
        12'hB80: begin m_cycle[63:32]   = nv; cyc_wr = 1; end
        12'hB02: begin m_instret[31:0]  = nv; ins_wr = 1; end
        12'hB82: begin m_instret[63:32] = nv; ins_wr = 1; end
        default: ;
      endcase
    end
    if (!cyc_wr) m_cycle = m_cycle + 1;
    if (!ins_wr && ir) m_instret = m_instret + 1;
    #1;
    check("trap_vector", bus.trap_vector, m_mtvec & 32'hFFFF_FFFC);
    check("mepc_out", bus.mepc_out, m_mepc);
    check("mie_out", bus.mie_out, m_mie);
  endtask

  task automatic rd_only(input logic [11:0] a, output logic [31:0] rd, output logic ill);
    cyc(a, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rd, ill);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.csr_addr = 12'h340; bus.csr_op = 2'b01; bus.csr_wdata = $urandom;
    bus.trap_valid = 1'b1; bus.trap_cause = $urandom; bus.trap_epc = $urandom;
    bus.mret = 1'b0; bus.instr_retire = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.csr_op = 2'b00; bus.trap_valid = 1'b0; bus.instr_retire = 1'b0;
    model_reset();
    check("rst_trap_vector", bus.trap_vector, 32'h80000000);
    check("rst_mepc_out", bus.mepc_out, 32'h0);
    check("rst_mie_out", bus.mie_out, 1'b0);
    $display("txn reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ill;
    logic [11:0] pool [13];
    pool = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
             12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h123, 12'h7C0};
    bus.csr_addr = 0; bus.csr_op = 0; bus.csr_wdata = 0; bus.trap_valid = 0;
    bus.trap_cause = 0; bus.trap_epc = 0; bus.mret = 0; bus.instr_retire = 0;

    do_reset();
    rd_only(12'h305, rd, ill); check("rst_mtvec_rd", rd, 32'h80000000);
    rd_only(12'hF14, rd, ill); check("mhartid_rd", rd, 32'h0);
    rd_only(12'h300, rd, ill); check("rst_mstatus_rd", rd, 32'h1800);

    cyc(12'h300, 2'b01, 32'hFFFFFFFF, 0, 0, 0, 0, 0, rd, ill);
    rd_only(12'h300, rd, ill); check("mstatus_rw", rd, 32'h1888);
    cyc(12'h300, 2'b11, 32'h8, 0, 0, 0, 0, 0, rd, ill);
    rd_only(12'h300, rd, ill); check("mstatus_rc", rd, 32'h1880);
    cyc(12'h300, 2'b10, 32'h8, 0, 0, 0, 0, 0, rd, ill);
    cyc(12'h000, 2'b00, 32'h0, 1, 32'd11, 32'h80000107, 0, 0, rd, ill);
    check("trap_mepc_out", bus.mepc_out, 32'h80000104);
    rd_only(12'h341, rd, ill); check("trap_mepc_rd", rd, 32'h80000104);
    rd_only(12'h342, rd, ill); check("trap_mcause_rd", rd, 32'd11);
    rd_only(12'h300, rd, ill); check("trap_mstatus_rd", rd, 32'h1880);
    check("trap_mie_out", bus.mie_out, 1'b0);
    cyc(12'h000, 2'b00, 32'h0, 0, 0, 0, 1, 0, rd, ill);
    rd_only(12'h300, rd, ill); check("mret_mstatus_rd", rd, 32'h1888);

    cyc(12'h340, 2'b01, 32'h12345678, 0, 0, 0, 0, 0, rd, ill);
    cyc(12'h340, 2'b01, 32'hDEADBEEF, 1, 32'd2, 32'h100, 0, 0, rd, ill);
    rd_only(12'h340, rd, ill); check("trap_drops_write", rd, 32'h12345678);
    cyc(12'hF14, 2'b01, 32'h5, 0, 0, 0, 0, 0, rd, ill); check("ro_rw_illegal", ill, 1'b1);
    rd_only(12'hF14, rd, ill); check("ro_unchanged", rd, 32'h0);
    cyc(12'hF14, 2'b10, 32'h0, 0, 0, 0, 0, 0, rd, ill); check("ro_rs0_legal", ill, 1'b0);

`ifdef CSR_COUNTERS_EN
    cyc(12'hB80, 2'b01, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    cyc(12'hB00, 2'b01, 32'hFFFFFFFE, 0, 0, 0, 0, 0, rd, ill);
    for (int i = 0; i < 3; i++) rd_only(12'h000, rd, ill);
    rd_only(12'hB00, rd, ill); check("mcycle_lo_wrap", rd, 32'h1);
    rd_only(12'hB80, rd, ill); check("mcycle_hi_carry", rd, 32'h1);
    cyc(12'hB02, 2'b01, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    cyc(12'hB82, 2'b01, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    for (int i = 0; i < 5; i++) cyc(12'h000, 2'b00, 32'h0, 0, 0, 0, 0, 1, rd, ill);
    rd_only(12'hB02, rd, ill); check("minstret_five", rd, 32'd5);
`else
    cyc(12'hB00, 2'b10, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    check("nocnt_rdata", rd, 32'h0);
    check("nocnt_illegal", ill, 1'b1);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [1:0]  op;
      logic [31:0] w;
      if (i == 200) begin
        do_reset();
        rd_only(12'h340, rd, ill); check("rst_mid_write", rd, 32'h0);
      end
      a  = pool[$urandom_range(0, 12)];
      op = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc(a, op, w, ($urandom_range(0, 7) == 0), $urandom, $urandom,
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rd, ill);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
